// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave front-end.
//   OKAY/EXOKAY/SLVERR/DECERR : AXI response codes
//   window_match()            : base-address window decode
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // True when addr and base agree on every bit at or above gp_w. Callers zero-extend both
  // operands from the AXI address width, so bits above that width always compare equal.
  function automatic logic window_match(input logic [63:0] addr, input logic [63:0] base,
                                        input int unsigned gp_w);
    return ((addr ^ base) >> gp_w) == 64'd0;
  endfunction

endpackage

// File: rtl/axi_lite_fifo.sv
// Synchronous FIFO used for the AW, W and AR queues.
//   clk_i, rst_ni      : clock, synchronous active-low reset (empties the queue)
//   push_i, data_i     : write one entry (caller guarantees not full)
//   pop_i              : drop the head entry (caller guarantees not empty)
//   full_o, empty_o    : status from the registered occupancy count
//   head_o             : oldest entry
module axi_lite_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_lite_slave_v2.sv
// AXI4-Lite slave front-end driving the GP read/write request interface.
//   s_axi_aclk, s_axi_aresetn : clock, synchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*     : AXI4-Lite slave port (awprot/arprot ignored)
//   write, write_addrs/data/strobe, write_done, write_error : GP write request
//   read, read_addrs, read_data, read_done, read_error      : GP read request
// AW/W/AR are queued; out-of-window accesses get DECERR with no GP activity, stalled GP
// requests get SLVERR after TIMEOUT_CYCLES (0 disables). B/R are registered single slots.
module axi_lite_slave_v2 import axi_lite_pkg::*; #(
  parameter int unsigned                    GP_ADDR_WIDTH      = 6,
  parameter int unsigned                    C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 12,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int unsigned                    FIFO_DEPTH         = 4,
  parameter int unsigned                    TIMEOUT_CYCLES     = 256
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            write,
  output logic [GP_ADDR_WIDTH-1:0]        write_addrs,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   write_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] write_strobe,
  input  logic                            write_done,
  input  logic                            write_error,
  output logic                            read,
  output logic [GP_ADDR_WIDTH-1:0]        read_addrs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   read_data,
  input  logic                            read_done,
  input  logic                            read_error
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_MAX = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // Holds the ready outputs low during reset and releases them one cycle after.
  logic rdy_q;
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) rdy_q <= 1'b0;
    else                rdy_q <= 1'b1;
  end

  // ---------------- queues ----------------
  logic          aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
  logic [AW-1:0] aw_head, ar_head;
  logic [DW+SW-1:0] w_head;
  logic          wr_complete, rd_complete;

  assign s_axi_awready = rdy_q & ~aw_full;
  assign s_axi_wready  = rdy_q & ~w_full;
  assign s_axi_arready = rdy_q & ~ar_full;

  axi_lite_fifo #(.Width(AW), .Depth(FIFO_DEPTH)) u_aw_fifo (
    .clk_i  (s_axi_aclk),
    .rst_ni (s_axi_aresetn),
    .push_i (s_axi_awvalid & s_axi_awready),
    .data_i (s_axi_awaddr),
    .pop_i  (wr_complete),
    .full_o (aw_full),
    .empty_o(aw_empty),
    .head_o (aw_head)
  );

  axi_lite_fifo #(.Width(DW + SW), .Depth(FIFO_DEPTH)) u_w_fifo (
    .clk_i  (s_axi_aclk),
    .rst_ni (s_axi_aresetn),
    .push_i (s_axi_wvalid & s_axi_wready),
    .data_i ({s_axi_wdata, s_axi_wstrb}),
    .pop_i  (wr_complete),
    .full_o (w_full),
    .empty_o(w_empty),
    .head_o (w_head)
  );

  axi_lite_fifo #(.Width(AW), .Depth(FIFO_DEPTH)) u_ar_fifo (
    .clk_i  (s_axi_aclk),
    .rst_ni (s_axi_aresetn),
    .push_i (s_axi_arvalid & s_axi_arready),
    .data_i (s_axi_araddr),
    .pop_i  (rd_complete),
    .full_o (ar_full),
    .empty_o(ar_empty),
    .head_o (ar_head)
  );

  // ---------------- write channel ----------------
  logic          wr_pending, wr_in_win, wr_timeout, bvalid_q;
  logic [1:0]    bresp_d, bresp_q;
  logic [TW-1:0] wr_cnt_q;

  // Once issued, the B slot stays free until this request completes, so wr_pending
  // remains asserted for the whole GP request without extra state.
  assign wr_pending  = ~aw_empty & ~w_empty & (~bvalid_q | s_axi_bready);
  assign wr_in_win   = window_match(64'(aw_head), 64'(BASE_ADDR), GP_ADDR_WIDTH);
  assign wr_timeout  = TO_EN && (wr_cnt_q == TO_MAX);
  assign wr_complete = wr_pending & (~wr_in_win | write_done | wr_timeout);

  assign write        = wr_pending & wr_in_win;
  assign write_addrs  = write ? aw_head[GP_ADDR_WIDTH-1:0] : '0;
  assign write_data   = write ? w_head[DW+SW-1:SW] : '0;
  assign write_strobe = write ? w_head[SW-1:0] : '0;

  always_comb begin
    bresp_d = SLVERR;
    if (!wr_in_win)      bresp_d = DECERR;
    else if (write_done) bresp_d = write_error ? SLVERR : OKAY;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_cnt_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      if (write && !wr_complete) wr_cnt_q <= wr_cnt_q + TW'(1);
      else                       wr_cnt_q <= '0;
      if (wr_complete) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;

  // ---------------- read channel ----------------
  logic          rd_pending, rd_in_win, rd_timeout, rvalid_q;
  logic [1:0]    rresp_d, rresp_q;
  logic [DW-1:0] rdata_d, rdata_q;
  logic [TW-1:0] rd_cnt_q;

  assign rd_pending  = ~ar_empty & (~rvalid_q | s_axi_rready);
  assign rd_in_win   = window_match(64'(ar_head), 64'(BASE_ADDR), GP_ADDR_WIDTH);
  assign rd_timeout  = TO_EN && (rd_cnt_q == TO_MAX);
  assign rd_complete = rd_pending & (~rd_in_win | read_done | rd_timeout);

  assign read       = rd_pending & rd_in_win;
  assign read_addrs = read ? ar_head[GP_ADDR_WIDTH-1:0] : '0;

  always_comb begin
    rresp_d = SLVERR;
    rdata_d = '0;
    if (!rd_in_win) begin
      rresp_d = DECERR;
    end else if (read_done) begin
      rresp_d = read_error ? SLVERR : OKAY;
      rdata_d = read_data;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rd_cnt_q <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      if (read && !rd_complete) rd_cnt_q <= rd_cnt_q + TW'(1);
      else                      rd_cnt_q <= '0;
      if (rd_complete) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_v2.sv
// Directed bench for axi_lite_slave_v2: vector tables for single writes/reads plus
// hand-written sequences for pipelining, B backpressure and reset during a write.
module tb_axi_lite_slave_v2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        write, write_done, write_error, read, read_done, read_error;
  logic [5:0]  write_addrs, read_addrs;
  logic [31:0] write_data, read_data;
  logic [3:0]  write_strobe;

  axi_lite_slave_v2 #(
    .GP_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12),
    .BASE_ADDR(12'h400), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
    .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .write(write), .write_addrs(write_addrs),
    .write_data(write_data), .write_strobe(write_strobe), .write_done(write_done),
    .write_error(write_error), .read(read), .read_addrs(read_addrs),
    .read_data(read_data), .read_done(read_done), .read_error(read_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;    // GP cycles before write_done (99 = never)
    bit          err;
    bit          win;
    logic [5:0]  exp_addr;
    int          exp_lat;  // negedges after cycle 1 until bvalid is seen
    logic [1:0]  exp_resp;
  } wvec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] gp_data;
    int          delay;
    bit          err;
    bit          win;
    logic [5:0]  exp_addr;
    int          exp_lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } rvec_t;

  wvec_t wv [6];
  rvec_t rv [5];

  task automatic run_wvec(input wvec_t v);
    int lat = -1;
    @(negedge clk);
    check("w_awready", 64'(awready), 64'(1));
    check("w_wready", 64'(wready), 64'(1));
    awaddr = v.addr; awvalid = 1'b1; wdata = v.data; wstrb = v.strb; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (bvalid) begin
        lat = i;
        break;
      end
      check("w_write_held", 64'(write), 64'(v.win));
      if (i == 0 && v.win) begin
        check("w_write_addrs", 64'(write_addrs), 64'(v.exp_addr));
        check("w_write_data", 64'(write_data), 64'(v.data));
        check("w_write_strobe", 64'(write_strobe), 64'(v.strb));
      end
      write_done  = (i == v.delay);
      write_error = (i == v.delay) && v.err;
    end
    write_done = 1'b0; write_error = 1'b0;
    check("w_latency", 64'(lat), 64'(v.exp_lat));
    check("w_bresp", 64'(bresp), 64'(v.exp_resp));
    check("w_write_dropped", 64'(write), 64'(0));
  endtask

  task automatic run_rvec(input rvec_t v);
    int lat = -1;
    @(negedge clk);
    check("r_arready", 64'(arready), 64'(1));
    araddr = v.addr; arvalid = 1'b1; read_data = v.gp_data;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (rvalid) begin
        lat = i;
        break;
      end
      check("r_read_held", 64'(read), 64'(v.win));
      if (i == 0 && v.win) check("r_read_addrs", 64'(read_addrs), 64'(v.exp_addr));
      read_done  = (i == v.delay);
      read_error = (i == v.delay) && v.err;
    end
    read_done = 1'b0; read_error = 1'b0;
    check("r_latency", 64'(lat), 64'(v.exp_lat));
    check("r_rresp", 64'(rresp), 64'(v.exp_resp));
    check("r_rdata", 64'(rdata), 64'(v.exp_rdata));
    check("r_read_dropped", 64'(read), 64'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] raddr [5];
    logic [11:0] baddr [3];
    logic [5:0]  a6;
    bit          ar_acc;
    int          gp_cnt;

    //       addr     data          strb  dly err win  addr   lat resp
    wv[0] = '{12'h408, 32'hDEADBEEF, 4'hF, 0,  1'b0, 1'b1, 6'h08, 1, 2'b00};
    wv[1] = '{12'h43C, 32'h12345678, 4'h3, 2,  1'b1, 1'b1, 6'h3C, 3, 2'b10};
    wv[2] = '{12'h500, 32'h55555555, 4'hF, 99, 1'b0, 1'b0, 6'h00, 1, 2'b11};
    wv[3] = '{12'h410, 32'hAABBCCDD, 4'h0, 0,  1'b0, 1'b1, 6'h10, 1, 2'b00};
    wv[4] = '{12'h404, 32'h01020304, 4'hC, 99, 1'b0, 1'b1, 6'h04, 8, 2'b10};
    wv[5] = '{12'h000, 32'hFFFFFFFF, 4'hF, 99, 1'b0, 1'b0, 6'h00, 1, 2'b11};
    //       addr     gp_data       dly err   win   addr   lat resp   rdata
    rv[0] = '{12'h408, 32'hA5A5A5A5, 0,  1'b0, 1'b1, 6'h08, 1, 2'b00, 32'hA5A5A5A5};
    rv[1] = '{12'h43C, 32'h00000000, 1,  1'b1, 1'b1, 6'h3C, 2, 2'b10, 32'h00000000};
    rv[2] = '{12'h540, 32'hFFFFFFFF, 99, 1'b0, 1'b0, 6'h00, 1, 2'b11, 32'h00000000};
    rv[3] = '{12'h404, 32'hCAFEF00D, 99, 1'b0, 1'b1, 6'h04, 8, 2'b10, 32'h00000000};
    rv[4] = '{12'h420, 32'h0BADC0DE, 3,  1'b0, 1'b1, 6'h20, 4, 2'b00, 32'h0BADC0DE};

    aresetn = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    write_done = 1'b0; write_error = 1'b0; read_data = '0; read_done = 1'b0;
    read_error = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_write", 64'(write), 64'(0));
    check("rst_read", 64'(read), 64'(0));
    aresetn = 1'b1;
    @(negedge clk);
    check("rel_awready", 64'(awready), 64'(1));
    check("rel_wready", 64'(wready), 64'(1));
    check("rel_arready", 64'(arready), 64'(1));

    for (int k = 0; k < 6; k++) run_wvec(wv[k]);
    for (int k = 0; k < 5; k++) run_rvec(rv[k]);

    // Pipelined reads: fill the AR queue with the GP side idle, then serve back-to-back
    raddr[0] = 12'h400; raddr[1] = 12'h404; raddr[2] = 12'h408; raddr[3] = 12'h40C;
    raddr[4] = 12'h41C;
    rready = 1'b1; read_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("pipe_arready_open", 64'(arready), 64'(1));
      araddr = raddr[k]; arvalid = 1'b1;
    end
    @(negedge clk);
    check("pipe_arready_full", 64'(arready), 64'(0));
    araddr = raddr[4];
    @(negedge clk);
    check("pipe_arready_full2", 64'(arready), 64'(0));
    ar_acc = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(negedge clk);
        if (ar_acc) arvalid = 1'b0;
        check("pipe_rvalid", 64'(rvalid), 64'(1));
        check("pipe_rdata", 64'(rdata), 64'(32'hA0000000 + 32'(j - 1)));
        check("pipe_rresp", 64'(rresp), 64'(0));
      end
      if (arvalid && arready) ar_acc = 1'b1;
      a6 = raddr[j][5:0];
      check("pipe_read", 64'(read), 64'(1));
      check("pipe_read_addrs", 64'(read_addrs), 64'(a6));
      read_done = 1'b1; read_data = 32'hA0000000 + 32'(j);
    end
    @(negedge clk);
    read_done = 1'b0;
    check("pipe_rvalid_last", 64'(rvalid), 64'(1));
    check("pipe_rdata_last", 64'(rdata), 64'(32'hA0000004));
    check("pipe_fifth_accepted", 64'(ar_acc), 64'(1));
    check("pipe_read_idle", 64'(read), 64'(0));

    // Backpressure: bready low while three writes are queued, write_done held high
    baddr[0] = 12'h40C; baddr[1] = 12'h414; baddr[2] = 12'h428;
    @(negedge clk);
    bready = 1'b0; write_done = 1'b1; gp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (write && write_done) gp_cnt++;
      check("bp_awready", 64'(awready), 64'(1));
      check("bp_wready", 64'(wready), 64'(1));
      awaddr = baddr[k]; awvalid = 1'b1; wdata = 32'(k); wstrb = 4'hF; wvalid = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      if (write && write_done) gp_cnt++;
      check("bp_bvalid_stable", 64'(bvalid), 64'(1));
      check("bp_bresp_stable", 64'(bresp), 64'(0));
    end
    check("bp_gp_completions", 64'(gp_cnt), 64'(1));
    @(negedge clk);
    bready = 1'b1;
    #1;
    check("bp_write_resume", 64'(write), 64'(1));
    check("bp_addr_e1", 64'(write_addrs), 64'(6'h14));
    @(negedge clk);
    check("bp_bvalid_e1", 64'(bvalid), 64'(1));
    check("bp_write_e2", 64'(write), 64'(1));
    check("bp_addr_e2", 64'(write_addrs), 64'(6'h28));
    @(negedge clk);
    check("bp_bvalid_e2", 64'(bvalid), 64'(1));
    check("bp_write_drained", 64'(write), 64'(0));
    @(negedge clk);
    write_done = 1'b0;
    check("bp_bvalid_drained", 64'(bvalid), 64'(0));

    // Reset while a GP write is in flight
    @(negedge clk);
    awaddr = 12'h430; awvalid = 1'b1; wdata = 32'h77777777; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("mrst_write_before", 64'(write), 64'(1));
    aresetn = 1'b0;
    @(negedge clk);
    check("mrst_write", 64'(write), 64'(0));
    check("mrst_write_addrs", 64'(write_addrs), 64'(0));
    check("mrst_awready", 64'(awready), 64'(0));
    check("mrst_wready", 64'(wready), 64'(0));
    check("mrst_arready", 64'(arready), 64'(0));
    check("mrst_bvalid", 64'(bvalid), 64'(0));
    check("mrst_rvalid", 64'(rvalid), 64'(0));
    aresetn = 1'b1;
    @(negedge clk);
    check("mrel_awready", 64'(awready), 64'(1));
    check("mrel_wready", 64'(wready), 64'(1));
    check("mrel_arready", 64'(arready), 64'(1));
    check("mrel_write", 64'(write), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check("mrel_no_bresp", 64'(bvalid), 64'(0));
    end
    run_wvec(wv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
